// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset/lock and releases sys_rst_n after stable lock.
// Define PLL_LOCK_TIMEOUT_EN to retry the PLL reset when lock does not arrive in time.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W = 8
) (
  input logic refclk,
  input logic rst_n,
  input logic pll_locked,
  input logic relock_req,
  input logic clr_count,
  output logic pll_rst,
  output logic sys_rst_n,
  output logic lock_ok,
  output logic [CNT_W-1:0] loss_count,
  output logic timeout_err
);
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;
  localparam int PS_MAX = RST_PULSE_CYCLES > STABLE_CYCLES ? RST_PULSE_CYCLES : STABLE_CYCLES;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int T_MAX = TIMEOUT_CYCLES > PS_MAX ? TIMEOUT_CYCLES : PS_MAX;
`else
  localparam int T_MAX = PS_MAX;
`endif
  localparam int TW = $clog2(T_MAX);
  localparam logic [TW-1:0] RST_END = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] STB_END = TW'(STABLE_CYCLES - 1);
  state_t state, next;
  logic [TW-1:0] timer;
  logic sync1, locked_s, tmo, loss;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) {locked_s, sync1} <= '0;
    else {locked_s, sync1} <= {sync1, pll_locked};
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);
  assign tmo = state == WAIT_LOCK && !locked_s && timer == TMO_END;
`else
  assign tmo = 1'b0;
`endif
  assign loss = state == RUN && !locked_s;
  // a loss wins over a simultaneous relock request so it is always counted
  always_comb begin
    next = state;
    case (state)
      RESET_PLL: next = timer == RST_END ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: next = locked_s ? STABLE : tmo ? RESET_PLL : WAIT_LOCK;
      STABLE:    next = !locked_s ? WAIT_LOCK : timer == STB_END ? RUN : STABLE;
      default:   next = (loss || relock_req) ? RESET_PLL : RUN;
    endcase
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET_PLL;
      timer <= '0;
      pll_rst <= 1'b1;
      sys_rst_n <= 1'b0;
      lock_ok <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= next;
      timer <= next != state ? '0 : timer + 1'b1;
      pll_rst <= next == RESET_PLL;
      sys_rst_n <= next == RUN;
      lock_ok <= next == RUN;
      timeout_err <= tmo;
    end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) loss_count <= '0;
    else if (clr_count) loss_count <= loss ? CNT_W'(1) : '0;
    else if (loss && !(&loss_count)) loss_count <= loss_count + 1'b1;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed lock/loss/retry scenarios plus random lock traffic,
// all checked against a phase-level reference model.
module tb_pll_lock_supervisor;
  localparam int RP = 4, SC = 8, TO = 32;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int EXP_RETRIES = 3;
`else
  localparam int EXP_RETRIES = 0;
`endif
  logic refclk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0, relock_req = 1'b0, clr_count = 1'b0;
  logic pll_rst, sys_rst_n, lock_ok, timeout_err;
  logic [1:0] loss_count;
  int n_cmp = 0, n_bad = 0;
  pll_lock_supervisor #(.RST_PULSE_CYCLES(RP), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .clr_count(clr_count), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_ok(lock_ok),
    .loss_count(loss_count), .timeout_err(timeout_err)
  );
  always #5 refclk = ~refclk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // phase: 0 pulsing PLL reset, 1 waiting for lock, 2 qualifying lock, 3 running
  int m_phase = 0, m_age = 0, m_streak = 0, m_cnt = 0;
  bit m_tmo = 1'b0, m_ls, m_lost;
  bit [1:0] m_hist = 2'b00;
  always @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_streak = 0; m_cnt = 0; m_tmo = 1'b0; m_hist = 2'b00;
    end else begin
      m_ls = m_hist[1];
      m_hist = {m_hist[0], pll_locked};
      m_tmo = 1'b0;
      m_lost = 1'b0;
      case (m_phase)
        0: begin
          m_age++;
          if (m_age == RP) begin m_phase = 1; m_age = 0; end
        end
        1: if (m_ls) begin m_phase = 2; m_streak = 1; end
           else begin
             m_age++;
`ifdef PLL_LOCK_TIMEOUT_EN
             if (m_age == TO) begin m_phase = 0; m_age = 0; m_tmo = 1'b1; end
`endif
           end
        2: if (!m_ls) begin m_phase = 1; m_age = 0; end
           else begin
             m_streak++;
             if (m_streak == SC + 1) m_phase = 3;
           end
        default: if (!m_ls || relock_req) begin m_lost = !m_ls; m_phase = 0; m_age = 0; end
      endcase
      if (m_lost) m_cnt = clr_count ? 1 : (m_cnt < 3 ? m_cnt + 1 : 3);
      else if (clr_count) m_cnt = 0;
    end
  always @(negedge refclk)
    check("outs", int'({pll_rst, sys_rst_n, lock_ok, loss_count, timeout_err}),
          int'({m_phase == 0, m_phase == 3, m_phase == 3, 2'(m_cnt), m_tmo}));
  task automatic edges_until(input int sel, input logic val, output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge refclk);
      #1;
      if ((sel == 0 ? pll_rst : sel == 1 ? sys_rst_n : lock_ok) == val) begin
        k = i;
        break;
      end
    end
  endtask
  initial begin
    int k, rises, tmos;
    logic prev;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_lock_ok", lock_ok, 0);
    check("rst_loss_count", loss_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    edges_until(0, 1'b0, k);
    check("pll_rst_len", k, RP);
    repeat (16) @(negedge refclk);
    pll_locked = 1'b1;
    edges_until(1, 1'b1, k);
    check("lock_latency", k, SC + 3);
    check("lock_ok_run", lock_ok, 1);
    repeat (4) @(negedge refclk);
    pll_locked = 1'b0;
    edges_until(1, 1'b0, k);
    check("loss_latency", k, 3);
    check("loss_lock_ok", lock_ok, 0);
    edges_until(0, 1'b0, k);
    check("relock_pulse_len", k, RP);
    check("loss_one", loss_count, 1);
    @(negedge refclk);
    repeat (3) begin
      pll_locked = 1'b1;
      repeat (20) @(negedge refclk);
      pll_locked = 1'b0;
      repeat (8) @(negedge refclk);
    end
    check("loss_saturated", loss_count, 3);
    pll_locked = 1'b1;
    repeat (20) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    clr_count = 1'b1;
    @(negedge refclk);
    clr_count = 1'b0;
    check("clr_with_loss", loss_count, 1);
    repeat (8) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (20) @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    check("relock_pll_rst", pll_rst, 1);
    check("relock_count", loss_count, 1);
    pll_locked = 1'b0;
    repeat (12) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    edges_until(1, 1'b1, k);
    check("glitch_restart", k, SC + 3);
    check("glitch_count", loss_count, 1);
    @(negedge refclk);
    for (int i = 0; i < 150; i++) begin
      pll_locked = $urandom_range(0, 9) < 7;
      repeat ($urandom_range(1, 30)) begin
        relock_req = $urandom_range(0, 19) == 0;
        clr_count = $urandom_range(0, 29) == 0;
        @(negedge refclk);
      end
    end
    relock_req = 1'b0;
    clr_count = 1'b0;
    pll_locked = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    prev = 1'b1;
    rises = 0;
    tmos = 0;
    repeat (120) begin
      @(negedge refclk);
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
      if (timeout_err) tmos++;
    end
    check("retry_pulses", rises, EXP_RETRIES);
    check("timeout_pulses", tmos, EXP_RETRIES);
    pll_locked = 1'b1;
    repeat (50) @(negedge refclk);
    check("pre_arst_run", sys_rst_n, 1);
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pll_rst", pll_rst, 1);
    check("arst_sys_rst_n", sys_rst_n, 0);
    check("arst_lock_ok", lock_ok, 0);
    check("arst_loss_count", loss_count, 0);
    check("arst_timeout_err", timeout_err, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (4) @(negedge refclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
